// File: rtl/muldiv_sequencer_if.sv
// Handshake and result bundle between the execute stage and the iterative mult/div engine.
// The master side belongs to the execute stage; the slave side belongs to muldiv_sequencer.
interface muldiv_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             multordiv;
   logic [WIDTH-1:0] srca;
   logic [WIDTH-1:0] srcb;
   logic             abort;
   logic             busy;
   logic             done;
   logic             hlwrite;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, multordiv, srca, srcb, abort,
      input  busy, done, hlwrite, hi, lo
   );

   modport slave (
      input  start, multordiv, srca, srcb, abort,
      output busy, done, hlwrite, hi, lo
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Radix-2 iterative multiply (shift-add) / divide (restoring) engine, one iteration per cycle.
// Define MULDIV_SIGNED_EN for two's-complement operands with sign-corrected results.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input logic               clk,
   input logic               reset,
   muldiv_sequencer_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      count_q, count_d;
   logic               div_q, div_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH-1:0]   rem_diff;
   logic [2*WIDTH-1:0] acc_step;
   logic [2*WIDTH-1:0] result;

`ifdef MULDIV_SIGNED_EN
   logic               neg_q, neg_d;
   logic               rem_neg_q, rem_neg_d;
   logic [WIDTH-1:0]   a_mag, b_mag;
`endif

   // The accumulator holds {partial, operand}: for multiply the low half is the
   // multiplier shifting out, for divide the dividend shifts out while quotient bits shift in.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q & {WIDTH{acc_q[0]}}};
      rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      rem_diff  = rem_shift[WIDTH-1:0] - opb_q;
      if (div_q) begin
         if (rem_shift >= {1'b0, opb_q}) begin
            acc_step = {rem_diff, acc_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_step = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_step = {mul_sum, acc_q[WIDTH-1:1]};
      end
   end

`ifdef MULDIV_SIGNED_EN
   // A zero divisor leaves the quotient as all ones; the remainder already equals srca
   // once its sign is restored, so only the quotient skips correction.
   always_comb begin
      a_mag  = bus.srca[WIDTH-1] ? -bus.srca : bus.srca;
      b_mag  = bus.srcb[WIDTH-1] ? -bus.srcb : bus.srcb;
      result = acc_step;
      if (div_q) begin
         if (neg_q && (opb_q != '0)) begin
            result[WIDTH-1:0] = -acc_step[WIDTH-1:0];
         end
         if (rem_neg_q) begin
            result[2*WIDTH-1:WIDTH] = -acc_step[2*WIDTH-1:WIDTH];
         end
      end else if (neg_q) begin
         result = -acc_step;
      end
   end
`else
   assign result = acc_step;
`endif

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      div_d   = div_q;
      opb_d   = opb_q;
      acc_d   = acc_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               state_d = RUN;
               count_d = CW'(WIDTH - 1);
               div_d   = bus.multordiv;
`ifdef MULDIV_SIGNED_EN
               opb_d     = b_mag;
               acc_d     = {{WIDTH{1'b0}}, a_mag};
               neg_d     = bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1];
               rem_neg_d = bus.srca[WIDTH-1];
`else
               opb_d = bus.srcb;
               acc_d = {{WIDTH{1'b0}}, bus.srca};
`endif
            end
         end
         RUN: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else begin
               acc_d   = acc_step;
               count_d = count_q - CW'(1);
               if (count_q == '0) begin
                  state_d = DONE;
                  count_d = '0;
                  hi_d    = result[2*WIDTH-1:WIDTH];
                  lo_d    = result[WIDTH-1:0];
                  done_d  = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         div_q   <= 1'b0;
         opb_q   <= '0;
         acc_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
`ifdef MULDIV_SIGNED_EN
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         div_q   <= div_d;
         opb_q   <= opb_d;
         acc_q   <= acc_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
`ifdef MULDIV_SIGNED_EN
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
`endif
      end
   end

   assign bus.busy    = (state_q != IDLE);
   assign bus.done    = done_q;
   assign bus.hlwrite = done_q;
   assign bus.hi      = hi_q;
   assign bus.lo      = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against an arithmetic reference model.
// Honours MULDIV_SIGNED_EN the same way the design does.
module tb_muldiv_sequencer;
   localparam int W = 32;

   logic clk;
   logic reset;
   int   n_compared;
   int   n_mismatched;
   logic [W-1:0] last_hi;
   logic [W-1:0] last_lo;

   muldiv_sequencer_if #(.WIDTH(W)) bus ();

   muldiv_sequencer #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference result straight from integer arithmetic.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic md,
                                 output logic [W-1:0] h, output logic [W-1:0] l);
      logic [63:0] p;
`ifdef MULDIV_SIGNED_EN
      longint sa, sb;
      int ia, ib;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ia = a;
      ib = b;
      if (!md) begin
         p = sa * sb;
         h = p[63:32];
         l = p[31:0];
      end else if (b == '0) begin
         h = a;
         l = '1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         h = '0;
         l = 32'h8000_0000;
      end else begin
         l = ia / ib;
         h = ia % ib;
      end
`else
      if (!md) begin
         p = {32'b0, a} * {32'b0, b};
         h = p[63:32];
         l = p[31:0];
      end else if (b == '0) begin
         h = a;
         l = '1;
      end else begin
         l = a / b;
         h = a % b;
      end
`endif
   endfunction

   function automatic logic [63:0] span(input int first, input int last);
      logic [63:0] m;
      m = '0;
      for (int i = first; i <= last; i++) m[i] = 1'b1;
      return m;
   endfunction

   // Issues one operation at edge 0 and records busy/done/hlwrite for cycles 1..W+3.
   // Optional abort, reset, or stray start pulses are injected in the named cycle.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic md,
                         input int abort_at, input int reset_at, input int pulse_at,
                         output logic [63:0] busy_tr, output logic [63:0] done_tr,
                         output logic [63:0] hlw_tr);
      busy_tr = '0;
      done_tr = '0;
      hlw_tr  = '0;
      bus.start     = 1'b1;
      bus.multordiv = md;
      bus.srca      = a;
      bus.srcb      = b;
      @(posedge clk); #1;
      bus.start     = 1'b0;
      bus.multordiv = ~md;
      bus.srca      = $urandom;
      bus.srcb      = $urandom;
      for (int c = 1; c <= W + 3; c++) begin
         busy_tr[c] = bus.busy;
         done_tr[c] = bus.done;
         hlw_tr[c]  = bus.hlwrite;
         bus.abort  = (c == abort_at);
         reset      = (c == reset_at);
         bus.start  = (c == pulse_at);
         if (c == pulse_at) begin
            bus.srca      = $urandom;
            bus.srcb      = $urandom;
            bus.multordiv = 1'($urandom);
         end
         @(posedge clk); #1;
      end
      bus.abort = 1'b0;
      bus.start = 1'b0;
      reset     = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.multordiv = 1'b0;
      bus.srca = '0;
      bus.srcb = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      n_compared++; if (bus.busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy got %0b want 0", bus.busy); end
      n_compared++; if (bus.done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_done got %0b want 0", bus.done); end
      n_compared++; if (bus.hlwrite !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_hlwrite got %0b want 0", bus.hlwrite); end
      n_compared++; if (bus.hi !== '0) begin n_mismatched++; $display("[TB] FAIL reset_hi got %h want 0", bus.hi); end
      n_compared++; if (bus.lo !== '0) begin n_mismatched++; $display("[TB] FAIL reset_lo got %h want 0", bus.lo); end
      last_hi = '0;
      last_lo = '0;
   endtask

   task automatic test_unsigned_mul;
      logic [63:0] btr, dtr, htr;
      logic [W-1:0] a, b, eh, el;
      for (int i = 0; i < 6; i++) begin
         a = (i == 0) ? 32'h0000_1234 : 32'($urandom);
         b = (i == 0) ? 32'h0000_5678 : 32'($urandom);
         model(a, b, 1'b0, eh, el);
         run_op(a, b, 1'b0, 0, 0, 0, btr, dtr, htr);
         n_compared++; if (btr !== span(1, W + 1)) begin n_mismatched++; $display("[TB] FAIL mul_busy got %h want %h", btr, span(1, W + 1)); end
         n_compared++; if (dtr !== span(W + 1, W + 1)) begin n_mismatched++; $display("[TB] FAIL mul_done got %h want %h", dtr, span(W + 1, W + 1)); end
         n_compared++; if (htr !== span(W + 1, W + 1)) begin n_mismatched++; $display("[TB] FAIL mul_hlwrite got %h want %h", htr, span(W + 1, W + 1)); end
         n_compared++; if ({bus.hi, bus.lo} !== {eh, el}) begin n_mismatched++; $display("[TB] FAIL mul_result %h*%h got %h_%h want %h_%h", a, b, bus.hi, bus.lo, eh, el); end
         last_hi = eh;
         last_lo = el;
      end
   endtask

   task automatic test_full_width;
      logic [63:0] btr, dtr, htr;
      logic [W-1:0] eh, el;
      model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, eh, el);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, 0, btr, dtr, htr);
      n_compared++; if ({bus.hi, bus.lo} !== {eh, el}) begin n_mismatched++; $display("[TB] FAIL full_width got %h_%h want %h_%h", bus.hi, bus.lo, eh, el); end
      n_compared++; if (dtr !== span(W + 1, W + 1)) begin n_mismatched++; $display("[TB] FAIL full_width_done got %h want %h", dtr, span(W + 1, W + 1)); end
      last_hi = eh;
      last_lo = el;
   endtask

   task automatic test_divide;
      logic [63:0] btr, dtr, htr;
      logic [W-1:0] a, b, eh, el;
      for (int i = 0; i < 8; i++) begin
         case (i)
            0: begin a = 32'd100; b = 32'd7; end
            1: begin a = 32'h0000_1234; b = '0; end
            2: begin a = 32'($urandom); b = '0; end
            3: begin a = 32'($urandom); b = 32'($urandom_range(1, 255)); end
            default: begin a = 32'($urandom); b = 32'($urandom) >> $urandom_range(0, 31); end
         endcase
         model(a, b, 1'b1, eh, el);
         run_op(a, b, 1'b1, 0, 0, 0, btr, dtr, htr);
         n_compared++; if (dtr !== span(W + 1, W + 1)) begin n_mismatched++; $display("[TB] FAIL div_done got %h want %h", dtr, span(W + 1, W + 1)); end
         n_compared++; if ({bus.hi, bus.lo} !== {eh, el}) begin n_mismatched++; $display("[TB] FAIL div_result %h/%h got hi=%h lo=%h want hi=%h lo=%h", a, b, bus.hi, bus.lo, eh, el); end
         last_hi = eh;
         last_lo = el;
      end
   endtask

`ifdef MULDIV_SIGNED_EN
   task automatic test_signed;
      logic [63:0] btr, dtr, htr;
      logic [W-1:0] a, b, eh, el;
      logic md;
      for (int i = 0; i < 8; i++) begin
         case (i)
            0: begin a = -32'sd7; b = 32'd2; md = 1'b1; end
            1: begin a = -32'sd3; b = 32'd5; md = 1'b0; end
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; md = 1'b1; end
            3: begin a = -32'sd9; b = '0; md = 1'b1; end
            default: begin a = 32'($urandom); b = 32'($urandom) >>> $urandom_range(0, 31); md = 1'($urandom); end
         endcase
         model(a, b, md, eh, el);
         run_op(a, b, md, 0, 0, 0, btr, dtr, htr);
         n_compared++; if ({bus.hi, bus.lo} !== {eh, el}) begin n_mismatched++; $display("[TB] FAIL signed md=%0b %h,%h got %h_%h want %h_%h", md, a, b, bus.hi, bus.lo, eh, el); end
         last_hi = eh;
         last_lo = el;
      end
   endtask
`endif

   task automatic test_abort;
      logic [63:0] btr, dtr, htr;
      int bad;
      run_op(32'($urandom), 32'($urandom), 1'b0, 10, 0, 0, btr, dtr, htr);
      n_compared++; if (btr !== span(1, 10)) begin n_mismatched++; $display("[TB] FAIL abort_busy got %h want %h", btr, span(1, 10)); end
      n_compared++; if (htr !== 64'd0) begin n_mismatched++; $display("[TB] FAIL abort_hlwrite got %h want 0", htr); end
      n_compared++; if ({bus.hi, bus.lo} !== {last_hi, last_lo}) begin n_mismatched++; $display("[TB] FAIL abort_hold got %h_%h want %h_%h", bus.hi, bus.lo, last_hi, last_lo); end
      bus.start = 1'b1;
      bus.abort = 1'b1;
      bus.multordiv = 1'b0;
      bus.srca = 32'($urandom);
      bus.srcb = 32'($urandom);
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bad = 0;
      for (int c = 0; c < W + 4; c++) begin
         if (bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      n_compared++; if (bad !== 0) begin n_mismatched++; $display("[TB] FAIL start_with_abort active_cycles got %0d want 0", bad); end
      n_compared++; if ({bus.hi, bus.lo} !== {last_hi, last_lo}) begin n_mismatched++; $display("[TB] FAIL start_with_abort_hold got %h_%h want %h_%h", bus.hi, bus.lo, last_hi, last_lo); end
   endtask

   task automatic test_start_ignored;
      logic [63:0] btr, dtr, htr;
      logic [W-1:0] a, b, eh, el;
      for (int i = 0; i < 2; i++) begin
         a = 32'($urandom);
         b = 32'($urandom_range(1, 100000));
         model(a, b, 1'b1, eh, el);
         run_op(a, b, 1'b1, 0, 0, (i == 0) ? 5 : W + 1, btr, dtr, htr);
         n_compared++; if (btr !== span(1, W + 1)) begin n_mismatched++; $display("[TB] FAIL ignored_start_busy got %h want %h", btr, span(1, W + 1)); end
         n_compared++; if (dtr !== span(W + 1, W + 1)) begin n_mismatched++; $display("[TB] FAIL ignored_start_done got %h want %h", dtr, span(W + 1, W + 1)); end
         n_compared++; if ({bus.hi, bus.lo} !== {eh, el}) begin n_mismatched++; $display("[TB] FAIL ignored_start_result got %h_%h want %h_%h", bus.hi, bus.lo, eh, el); end
         last_hi = eh;
         last_lo = el;
      end
   endtask

   task automatic test_reset_mid_op;
      logic [63:0] btr, dtr, htr;
      logic [W-1:0] a, b, eh, el;
      run_op(32'($urandom), 32'($urandom), 1'b0, 0, 20, 0, btr, dtr, htr);
      n_compared++; if (btr !== span(1, 20)) begin n_mismatched++; $display("[TB] FAIL midreset_busy got %h want %h", btr, span(1, 20)); end
      n_compared++; if (htr !== 64'd0) begin n_mismatched++; $display("[TB] FAIL midreset_hlwrite got %h want 0", htr); end
      n_compared++; if ({bus.hi, bus.lo} !== 64'd0) begin n_mismatched++; $display("[TB] FAIL midreset_result got %h_%h want 0", bus.hi, bus.lo); end
      a = 32'($urandom);
      b = 32'($urandom);
      model(a, b, 1'b0, eh, el);
      run_op(a, b, 1'b0, 0, 0, 0, btr, dtr, htr);
      n_compared++; if (dtr !== span(W + 1, W + 1)) begin n_mismatched++; $display("[TB] FAIL post_reset_done got %h want %h", dtr, span(W + 1, W + 1)); end
      n_compared++; if ({bus.hi, bus.lo} !== {eh, el}) begin n_mismatched++; $display("[TB] FAIL post_reset_result got %h_%h want %h_%h", bus.hi, bus.lo, eh, el); end
      last_hi = eh;
      last_lo = el;
   endtask

   initial begin
      n_compared = 0;
      n_mismatched = 0;
      test_reset();
      test_unsigned_mul();
      test_full_width();
      test_divide();
`ifdef MULDIV_SIGNED_EN
      test_signed();
`endif
      test_abort();
      test_start_ignored();
      test_reset_mid_op();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end
endmodule
